// File: rtl/uart_receiver_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | uart_receiver_pkg : UART frame constants and FSM states.             |
// | Revision 1.0                                                         |
// +----------------------------------------------------------------------+
package uart_receiver_pkg;

    localparam int c_DEFAULT_CLKS_PER_BIT = 434;
    localparam int c_FRAME_BITS           = 8;

    // Encodings are shared with the SoC UART transmitter.
    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_START = 2'd1,
        S_DATA  = 2'd2,
        S_STOP  = 2'd3
    } uart_state_t;

endpackage
`default_nettype wire

// File: rtl/uart_receiver_sync_2ff.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | sync_2ff : two-flop synchronizer with asynchronous active-low reset. |
// | Revision 1.0                                                         |
// +----------------------------------------------------------------------+
module sync_2ff #(
    parameter logic RESET_VAL = 1'b0
) (
    input  logic clk,
    input  logic rst_n,
    input  logic i_d,
    output logic o_q
);

    logic r_meta;
    logic r_sync;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_meta <= RESET_VAL;
            r_sync <= RESET_VAL;
        end else begin
            r_meta <= i_d;
            r_sync <= r_meta;
        end
    end

    assign o_q = r_sync;

endmodule
`default_nettype wire

// File: rtl/uart_receiver.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | uart_receiver : 8N1 serial receiver with sticky ready/error flags.   |
// | Revision 1.0                                                         |
// +----------------------------------------------------------------------+
module uart_receiver
    import uart_receiver_pkg::*;
#(
    parameter int CLKS_PER_BIT = c_DEFAULT_CLKS_PER_BIT
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    rx_i,
    input  logic                    clear_i,
    output logic [c_FRAME_BITS-1:0] rx_data_o,
    output logic                    rx_flag_o,
    output logic                    frame_err_o,
    output logic                    overrun_o,
    output logic                    busy_o
);

    localparam int c_BAUD_W = $clog2(CLKS_PER_BIT);
    localparam logic [c_BAUD_W-1:0] c_BAUD_LAST = c_BAUD_W'(CLKS_PER_BIT - 1);
    localparam logic [c_BAUD_W-1:0] c_HALF_LAST = c_BAUD_W'(CLKS_PER_BIT / 2 - 1);
    localparam logic [2:0]          c_LAST_BIT  = 3'(c_FRAME_BITS - 1);

    logic                    w_rx_s;
    uart_state_t             r_state;
    logic                    r_armed;
    logic [c_BAUD_W-1:0]     r_baud;
    logic [2:0]              r_bit_cnt;
    logic [c_FRAME_BITS-1:0] r_shift;
    logic                    r_stop_seen;
    logic                    r_stop_bit;
    logic [c_FRAME_BITS-1:0] r_data;
    logic                    r_flag;
    logic                    r_ferr;
    logic                    r_ovr;
    logic                    r_busy;

    sync_2ff #(
        .RESET_VAL (1'b0)
    ) u_rx_sync (
        .clk   (clk),
        .rst_n (reset),
        .i_d   (rx_i),
        .o_q   (w_rx_s)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state     <= S_IDLE;
            r_armed     <= 1'b0;
            r_baud      <= '0;
            r_bit_cnt   <= '0;
            r_shift     <= '0;
            r_stop_seen <= 1'b0;
            r_stop_bit  <= 1'b0;
            r_data      <= '0;
            r_flag      <= 1'b0;
            r_ferr      <= 1'b0;
            r_ovr       <= 1'b0;
            r_busy      <= 1'b0;
        end else begin
            if (clear_i) begin
                r_flag <= 1'b0;
                r_ferr <= 1'b0;
                r_ovr  <= 1'b0;
            end

            case (r_state)
                S_IDLE: begin
                    r_baud      <= '0;
                    r_bit_cnt   <= '0;
                    r_stop_seen <= 1'b0;
                    r_busy      <= 1'b0;
                    // A low line is only a start once a high level has been seen.
                    if (w_rx_s) begin
                        r_armed <= 1'b1;
                    end else if (r_armed) begin
                        r_armed <= 1'b0;
                        r_state <= S_START;
                    end
                end

                S_START: begin
                    r_busy <= 1'b1;
                    if (r_baud == c_HALF_LAST) begin
                        r_baud <= '0;
                        if (w_rx_s) begin
                            r_state <= S_IDLE;
                            r_busy  <= 1'b0;
                        end else begin
                            r_state <= S_DATA;
                        end
                    end else begin
                        r_baud <= r_baud + c_BAUD_W'(1);
                    end
                end

                S_DATA: begin
                    r_busy <= 1'b1;
                    if (r_baud == c_BAUD_LAST) begin
                        r_baud             <= '0;
                        r_shift[r_bit_cnt] <= w_rx_s;
                        r_bit_cnt          <= r_bit_cnt + 3'd1;
                        if (r_bit_cnt == c_LAST_BIT) begin
                            r_state <= S_STOP;
                        end
                    end else begin
                        r_baud <= r_baud + c_BAUD_W'(1);
                    end
                end

                S_STOP: begin
                    // Stop is sampled first; flags commit on the following edge.
                    if (!r_stop_seen) begin
                        r_busy <= 1'b1;
                        if (r_baud == c_BAUD_LAST) begin
                            r_stop_seen <= 1'b1;
                            r_stop_bit  <= w_rx_s;
                        end else begin
                            r_baud <= r_baud + c_BAUD_W'(1);
                        end
                    end else begin
                        r_state     <= S_IDLE;
                        r_baud      <= '0;
                        r_stop_seen <= 1'b0;
                        r_busy      <= 1'b0;
                        if (r_stop_bit) begin
                            r_data <= r_shift;
                            r_flag <= 1'b1;
                            r_ovr  <= clear_i ? 1'b0 : (r_ovr | r_flag);
                        end else begin
                            r_ferr <= 1'b1;
                        end
                    end
                end

                default: begin
                    r_state <= S_IDLE;
                    r_baud  <= '0;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    assign rx_data_o   = r_data;
    assign rx_flag_o   = r_flag;
    assign frame_err_o = r_ferr;
    assign overrun_o   = r_ovr;
    assign busy_o      = r_busy;

endmodule
`default_nettype wire
